conv_seq_ctrl: RTL

- Hardware sequencer for the conv accelerator top.
- Generates, from a single start pulse, the per-row control schedule for the psum FIFOs and load strobes: start_conv, set_wgt, set_ifm, wr_en_k/rd_en_k, wr_clr, rd_clr.
- Also issues read requests to the IFM/weight buffers.
- Replaces hand-driven stimulus; sits between the host command interface and the accelerator top.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/fifo_win_gen.sv | 40 ++++
 rtl/conv_seq_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROW   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int CNT_W_DEF       = 8;
    localparam int KERNEL_SIZE_DEF = 3;
    localparam int IFM_W_DEF       = 9;
    localparam int NUM_ROWS_DEF    = 7;
    localparam int OFM_SIZE_DEF    = 7;

    // One gap cycle plus one cycle per streamed IFM column.
    function automatic int row_len(input int ifm_w);
        return ifm_w + 1;
    endfunction

    localparam int ROW_LEN = row_len(IFM_W_DEF);

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_win_gen.sv
// Write/read window decode for one psum FIFO (index K_IDX).
module fifo_win_gen import conv_pkg::*; #(
    parameter int K_IDX       = 0,
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int NUM_ROWS    = NUM_ROWS_DEF,
    parameter int OFM_SIZE    = OFM_SIZE_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  state_t           state,
    input  logic [CNT_W-1:0] r,
    input  logic [CNT_W-1:0] t,
    output logic             wr_en,
    output logic             rd_en
);

    // Write window opens at c=KERNEL_SIZE, i.e. t=KERNEL_SIZE+1.
    localparam int WR_T0      = KERNEL_SIZE + 1;
    localparam int DRAIN_FIFO = min_i(NUM_ROWS, KERNEL_SIZE) - 1;

    int ri, ti;
    assign ri = int'(r);
    assign ti = int'(t);

    // Window decode; DRAIN t=0 behaves as the gap after the last row (r=NUM_ROWS).
    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        if ((state == S_ROW || state == S_DRAIN) && ti == 0 && ri >= 1)
            wr_en = (K_IDX <= min_i(ri - 1, KERNEL_SIZE - 1));
        if (state == S_ROW) begin
            if (ti >= WR_T0)
                wr_en = (K_IDX <= min_i(ri, KERNEL_SIZE - 1));
            if (ti >= 1 && ti <= OFM_SIZE)
                rd_en = (K_IDX < min_i(ri, KERNEL_SIZE));
        end
        if (state == S_DRAIN && ti >= 2 && ti <= OFM_SIZE + 1)
            rd_en = (K_IDX == DRAIN_FIFO);
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Per-row control sequencer for the conv accelerator: FSM, counters, registered strobes.
module conv_seq_ctrl import conv_pkg::*; #(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int IFM_W       = IFM_W_DEF,
    parameter int NUM_ROWS    = NUM_ROWS_DEF,
    parameter int OFM_SIZE    = OFM_SIZE_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   hold,
    output logic                   busy,
    output logic                   done,
    output logic                   start_conv,
    output logic                   set_wgt,
    output logic                   set_ifm,
    output logic                   ifm_rd,
    output logic                   wgt_rd,
    output logic [KERNEL_SIZE-1:0] wr_en,
    output logic [KERNEL_SIZE-1:0] rd_en,
    output logic                   wr_clr,
    output logic                   rd_clr,
    output logic [CNT_W-1:0]       row_idx,
    output logic [CNT_W-1:0]       col_idx
);

    if (OFM_SIZE != IFM_W - KERNEL_SIZE + 1) begin : g_bad_ofm
        $error("conv_seq_ctrl: OFM_SIZE must equal IFM_W-KERNEL_SIZE+1");
    end

    localparam logic [CNT_W-1:0] T_ROW_LAST   = CNT_W'(row_len(IFM_W) - 1);
    localparam logic [CNT_W-1:0] R_LAST       = CNT_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] R_DRAIN      = CNT_W'(NUM_ROWS);
    localparam logic [CNT_W-1:0] T_DRAIN_LAST = CNT_W'(OFM_SIZE + 1);
    localparam logic [CNT_W-1:0] T_RD_CLR     = CNT_W'(OFM_SIZE + 1);

    state_t           state, nstate;
    logic [CNT_W-1:0] r, t, nr, nt;

    logic                   n_busy, n_done, n_start_conv, n_set_wgt, n_set_ifm;
    logic                   n_ifm_rd, n_wgt_rd, n_wr_clr, n_rd_clr;
    logic [KERNEL_SIZE-1:0] n_wr_en, n_rd_en;

    // Next state and counters; hold freezes everything outside IDLE.
    always_comb begin
        nstate = state;
        nr     = r;
        nt     = t;
        if (!(hold && state != S_IDLE)) begin
            case (state)
                S_IDLE: if (start) begin
                    nstate = S_ROW;
                    nr     = '0;
                    nt     = '0;
                end
                S_ROW: if (t == T_ROW_LAST) begin
                    nt = '0;
                    if (r == R_LAST) begin
                        nstate = S_DRAIN;
                        nr     = R_DRAIN;
                    end else begin
                        nr = r + 1'b1;
                    end
                end else begin
                    nt = t + 1'b1;
                end
                S_DRAIN: if (t == T_DRAIN_LAST) begin
                    nstate = S_DONE;
                    nr     = '0;
                    nt     = '0;
                end else begin
                    nt = t + 1'b1;
                end
                default: nstate = S_IDLE;
            endcase
        end
    end

    // Strobe decode from next state so registered outputs line up with row_idx/col_idx.
    always_comb begin
        n_busy       = (nstate == S_ROW) || (nstate == S_DRAIN);
        n_done       = (nstate == S_DONE);
        n_set_wgt    = (nstate == S_ROW);
        n_wgt_rd     = (nstate == S_ROW) && (nt == '0);
        n_set_ifm    = (nstate == S_ROW) && (nt != '0);
        n_ifm_rd     = (nstate == S_ROW) && (nt != '0);
        n_start_conv = (nstate == S_ROW) && (nr == '0) && (nt == '0);
        n_wr_clr     = ((nstate == S_ROW) && (nr != '0) && (nt == CNT_W'(1)))
                    || ((nstate == S_DRAIN) && (nt == CNT_W'(1)));
        n_rd_clr     = (nstate == S_ROW) && (nr != '0) && (nt == T_RD_CLR);
    end

    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_win
        fifo_win_gen #(
            .K_IDX      (k),
            .KERNEL_SIZE(KERNEL_SIZE),
            .NUM_ROWS   (NUM_ROWS),
            .OFM_SIZE   (OFM_SIZE),
            .CNT_W      (CNT_W)
        ) u_win (
            .state(nstate),
            .r    (nr),
            .t    (nt),
            .wr_en(n_wr_en[k]),
            .rd_en(n_rd_en[k])
        );
    end

    // State, counters and all output strobes.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            r          <= '0;
            t          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_conv <= 1'b0;
            set_wgt    <= 1'b0;
            set_ifm    <= 1'b0;
            ifm_rd     <= 1'b0;
            wgt_rd     <= 1'b0;
            wr_en      <= '0;
            rd_en      <= '0;
            wr_clr     <= 1'b0;
            rd_clr     <= 1'b0;
        end else begin
            state      <= nstate;
            r          <= nr;
            t          <= nt;
            busy       <= n_busy;
            done       <= n_done;
            start_conv <= n_start_conv;
            set_wgt    <= n_set_wgt;
            set_ifm    <= n_set_ifm;
            ifm_rd     <= n_ifm_rd;
            wgt_rd     <= n_wgt_rd;
            wr_en      <= n_wr_en;
            rd_en      <= n_rd_en;
            wr_clr     <= n_wr_clr;
            rd_clr     <= n_rd_clr;
        end
    end

    assign row_idx = r;
    assign col_idx = t;

endmodule
